// File: rtl/expr_inverse_solver.sv
// Sequential inverse of out = ((a + b) * d) - c (mod 16): finds the smallest sum s that reproduces y.
// Optional macro INV_SOLN_COUNT_EN: full scan of 0..SMAX with a saturating match count on `count`.
module expr_inverse_solver #(
    parameter int SMAX = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] y,
    input  logic [1:0] c,
    input  logic [1:0] d,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [2:0] s_out,
    output logic [1:0] a_out,
    output logic [1:0] b_out
`ifdef INV_SOLN_COUNT_EN
    ,
    output logic [2:0] count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    localparam logic [2:0] S_LAST = 3'(SMAX);

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [3:0] y_q, y_d;
    logic [1:0] c_q, c_d;
    logic [1:0] d_q, d_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       found_q, found_d;
    logic [2:0] s_out_q, s_out_d;
    logic [1:0] a_out_q, a_out_d;
    logic [1:0] b_out_q, b_out_d;

    logic [3:0] prod_lo;
    logic [3:0] chk;
    logic       match;

    // Only the result mod 16 is compared, so the 4-bit product is sufficient.
    assign prod_lo = {1'b0, s_q} * {2'b00, d_q};
    assign chk     = prod_lo - {2'b00, c_q};
    assign match   = (chk == y_q);

`ifdef INV_SOLN_COUNT_EN
    logic       hit_q, hit_d;
    logic [2:0] best_q, best_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] count_q, count_d;
    logic       hit_now;
    logic [2:0] best_now;
    logic [2:0] cnt_now;

    // Running view including the candidate under test this cycle.
    assign hit_now  = hit_q | match;
    assign best_now = hit_q ? best_q : s_q;
    assign cnt_now  = (match && (cnt_q != 3'd7)) ? cnt_q + 3'd1 : cnt_q;
`endif

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        s_d     = s_q;
        y_d     = y_q;
        c_d     = c_q;
        d_d     = d_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        found_d = found_q;
        s_out_d = s_out_q;
`ifdef INV_SOLN_COUNT_EN
        hit_d   = hit_q;
        best_d  = best_q;
        cnt_d   = cnt_q;
        count_d = count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    y_d     = y;
                    c_d     = c;
                    d_d     = d;
                    s_d     = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SEARCH;
`ifdef INV_SOLN_COUNT_EN
                    hit_d   = 1'b0;
                    best_d  = 3'd0;
                    cnt_d   = 3'd0;
`endif
                end
            end

            ST_SEARCH: begin
`ifdef INV_SOLN_COUNT_EN
                hit_d  = hit_now;
                best_d = best_now;
                cnt_d  = cnt_now;
                if (s_q == S_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    found_d = hit_now;
                    s_out_d = hit_now ? best_now : 3'd0;
                    count_d = cnt_now;
                end else begin
                    s_d = s_q + 3'd1;
                end
`else
                if (match) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                    s_out_d = s_q;
                end else if (s_q == S_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    s_out_d = 3'd0;
                end else begin
                    s_d = s_q + 3'd1;
                end
`endif
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // a saturates at 3; b = s - 3 for s >= 4, i.e. s[1:0] + 1 modulo 4.
        a_out_d = (s_out_d > 3'd3) ? 2'd3 : s_out_d[1:0];
        b_out_d = (s_out_d > 3'd3) ? s_out_d[1:0] + 2'd1 : 2'd0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= 3'd0;
            y_q     <= 4'd0;
            c_q     <= 2'd0;
            d_q     <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            s_out_q <= 3'd0;
            a_out_q <= 2'd0;
            b_out_q <= 2'd0;
`ifdef INV_SOLN_COUNT_EN
            hit_q   <= 1'b0;
            best_q  <= 3'd0;
            cnt_q   <= 3'd0;
            count_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            y_q     <= y_d;
            c_q     <= c_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            s_out_q <= s_out_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
`ifdef INV_SOLN_COUNT_EN
            hit_q   <= hit_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign s_out = s_out_q;
    assign a_out = a_out_q;
    assign b_out = b_out_q;
`ifdef INV_SOLN_COUNT_EN
    assign count = count_q;
`endif

endmodule

// File: tb/tb_expr_inverse_solver.sv
// Bench for expr_inverse_solver: vector table through a scoreboard queue, plus handshake and mid-search reset sequences.
// Latency is counted so the cycle right after the start edge is 1 and the done cycle after a match at k is k+2.
module tb_expr_inverse_solver;

    localparam int SMAX = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] y     = 4'd0;
    logic [1:0] c     = 2'd0;
    logic [1:0] d     = 2'd0;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] s_out;
    logic [1:0] a_out;
    logic [1:0] b_out;
`ifdef INV_SOLN_COUNT_EN
    logic [2:0] count;
`endif

    expr_inverse_solver #(.SMAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .y     (y),
        .c     (c),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .found (found),
        .s_out (s_out),
        .a_out (a_out),
        .b_out (b_out)
`ifdef INV_SOLN_COUNT_EN
        ,
        .count (count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] y;
        logic [1:0] c;
        logic [1:0] d;
        logic       fnd;
        logic [2:0] s;
        logic [1:0] a;
        logic [1:0] b;
        int         lat;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [3:0] vy, input logic [1:0] vc, input logic [1:0] vd);
        @(negedge clk);
        y     = vy;
        c     = vc;
        d     = vd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after an edge with lat0 = latency count at that point; returns latency of the done cycle.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", lat);
        end
    endtask

    task automatic check_result(input string tag, input int lat);
        vec_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got done with empty queue, expected a pending solve", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " found"}, found, e.fnd);
            check({tag, " s_out"}, s_out, e.s);
            check({tag, " a_out"}, a_out, e.a);
            check({tag, " b_out"}, b_out, e.b);
            check({tag, " latency"}, lat, e.lat);
            check({tag, " busy_in_done"}, busy, 1);
`ifdef INV_SOLN_COUNT_EN
            check({tag, " count"}, count, e.cnt);
`endif
        end
    endtask

    function automatic vec_t expect_of(input vec_t v);
        vec_t e;
        e = v;
`ifdef INV_SOLN_COUNT_EN
        e.lat = SMAX + 2;
`endif
        return e;
    endfunction

    task automatic post_done(input string tag);
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, done, 0);
        check({tag, " busy_idle"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        sb_q.push_back(expect_of(v));
        launch(v.y, v.c, v.d);
        check({tag, " busy_after_start"}, busy, 1);
        wait_done(1, lat);
        check_result(tag, lat);
        post_done(tag);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        int lat;
        int n_done;

        //            y      c     d     fnd   s     a     b    lat cnt
        vecs[0]  = '{4'd5,  2'd1, 2'd2, 1'b1, 3'd3, 2'd3, 2'd0, 5, 3'd1};
        vecs[1]  = '{4'd2,  2'd0, 2'd3, 1'b1, 3'd6, 2'd3, 2'd3, 8, 3'd1};
        vecs[2]  = '{4'd3,  2'd0, 2'd2, 1'b0, 3'd0, 2'd0, 2'd0, 8, 3'd0};
        vecs[3]  = '{4'd14, 2'd2, 2'd0, 1'b1, 3'd0, 2'd0, 2'd0, 2, 3'd7};
        vecs[4]  = '{4'd0,  2'd0, 2'd1, 1'b1, 3'd0, 2'd0, 2'd0, 2, 3'd1};
        vecs[5]  = '{4'd4,  2'd1, 2'd1, 1'b1, 3'd5, 2'd3, 2'd2, 7, 3'd1};
        vecs[6]  = '{4'd1,  2'd3, 2'd3, 1'b0, 3'd0, 2'd0, 2'd0, 8, 3'd0};
        vecs[7]  = '{4'd2,  2'd1, 2'd3, 1'b1, 3'd1, 2'd1, 2'd0, 3, 3'd1};
        vecs[8]  = '{4'd13, 2'd3, 2'd0, 1'b1, 3'd0, 2'd0, 2'd0, 2, 3'd7};
        vecs[9]  = '{4'd15, 2'd3, 2'd2, 1'b1, 3'd1, 2'd1, 2'd0, 3, 3'd1};
        vecs[10] = '{4'd10, 2'd2, 2'd2, 1'b1, 3'd6, 2'd3, 2'd3, 8, 3'd1};
        vecs[11] = '{4'd2,  2'd0, 2'd1, 1'b1, 3'd2, 2'd2, 2'd0, 4, 3'd1};

        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset found", found, 0);
        check("reset s_out", s_out, 0);
        check("reset a_out", a_out, 0);
        check("reset b_out", b_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table runs back-to-back: each start lands in the IDLE cycle right after the previous done.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed mid-search with different operands must be ignored.
        sb_q.push_back(expect_of(vecs[0]));
        launch(vecs[0].y, vecs[0].c, vecs[0].d);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        y     = 4'd2;
        c     = 2'd0;
        d     = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(4, lat);
        check_result("busy_start", lat);
        post_done("busy_start");
        count_dones(12, n_done);
        check("busy_start no_queued_done", n_done, 0);

        // Back-to-back acceptance in the cycle after done.
        run_vec(vecs[1], "b2b_first");
        run_vec(vecs[5], "b2b_second");

        // Reset asserted while candidate 3 is under test.
        launch(4'd2, 2'd0, 2'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst found", found, 0);
        check("midrst s_out", s_out, 0);
        check("midrst a_out", a_out, 0);
        check("midrst b_out", b_out, 0);
`ifdef INV_SOLN_COUNT_EN
        check("midrst count", count, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_dones(12, n_done);
        check("midrst no_stale_done", n_done, 0);
        check("midrst busy_after_release", busy, 0);
        run_vec(vecs[1], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_inverse_solver.md
# expr_inverse_solver

Sequential inverse of the 2-bit expression unit `out = ((a + b) * d) - c`, truncated to 4 bits. Given a 4-bit result `y` and the operands `c` and `d`, the block searches the candidate sums `s = a + b` one per cycle. It reports the smallest `s` satisfying `((s * d) - c) mod 16 == y`, split back into 2-bit operands `a` and `b`. It sits on the decode/check side of the datapath, downstream of the expression unit, behind a start/done handshake.

## Interface
- `SMAX`, default 6: largest candidate sum searched. Legal range 1..7; 6 is the largest `a + b` for 2-bit operands.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: request a solve. Sampled only in IDLE.
- `y` input, 4: expression result to invert. Captured on accepted `start`.
- `c` input, 2: subtrahend operand. Captured on accepted `start`.
- `d` input, 2: multiplier operand. Captured on accepted `start`.
- `busy` output, 1: high in SEARCH and DONE.
- `done` output, 1: one-cycle pulse; the result outputs are valid while it is high.
- `found` output, 1: a matching `s` exists.
- `s_out` output, 3: matching sum, or 0 if none.
- `a_out` output, 2: `min(s_out, 3)`.
- `b_out` output, 2: `s_out - a_out`.
- `count` output, 3: number of matching candidates. Present only with `INV_SOLN_COUNT_EN`.

## Operation
- The FSM has three states: IDLE, SEARCH and DONE.
- **IDLE**
  - `start` = 1 captures `y`, `c` and `d`, clears the candidate counter `s` to 0, and moves to SEARCH.
  - `start` = 0 stays in IDLE.
- **SEARCH**, one candidate per cycle:
  - `prod = s * d`, 5 bits, with no overflow since the maximum is 21.
  - `chk = (prod - c)` truncated to 4 bits, so wrap-around is modulo 16.
  - Match is `chk == y_reg`.
  - On a match, latch `s`, set `found` = 1 and go to DONE.
  - With no match and `s == SMAX`, set `found` = 0, `s_out` = 0 and go to DONE.
  - Otherwise increment `s`.
- **DONE**: `done` = 1 for exactly one cycle, then return to IDLE.
- The result outputs hold their values until the next accepted `start`.
- `start` while `busy` = 1 is ignored; it is not queued.
- `d` = 0: `chk = (-c) mod 16` for every candidate. The first candidate, `s` = 0, matches if any candidate does.
- Operand split: `a_out` saturates at 3 and `b_out` takes the remainder. For example, `s` = 5 gives `a_out` = 3, `b_out` = 2.
- Reset, including reset asserted mid-search:
  - The FSM returns to IDLE and the captured registers clear.
  - `busy`, `done`, `found`, `s_out`, `a_out`, `b_out` and `count` all go to 0.
  - No stale `done` is produced after reset is released.

## Timing
- Edge E samples `start`. SEARCH evaluates candidate `s` in the cycle after edge E+s.
- With a match at candidate `k`, `done` is high in the cycle after edge E+k+1. Latency is k+2 cycles from the start edge to the `done` cycle.
- With no match, `done` is high after edge E+SMAX+1. Latency is SMAX+2.
- `found`, `s_out`, `a_out` and `b_out` update on the same edge that raises `done`.
- A new `start` is accepted in the cycle after the `done` cycle, which is IDLE again. Back-to-back throughput is latency+1 cycles per solve.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Configuration
- Macro: `INV_SOLN_COUNT_EN`.
- **Defined**
  - The search always scans `s` = 0..SMAX with no early exit.
  - `count` gives the number of matches. It saturates at 7.
  - `s_out` is the smallest match.
  - Latency is fixed at SMAX+2.
- **Undefined**
  - The `count` port and its counter logic are omitted.
  - The search exits early on the first match, as described under Operation.

## Test plan
- `y`=5, `c`=1, `d`=2:
  - Response: `found`=1, `s_out`=3, `a_out`=3, `b_out`=0.
  - `done` 5 cycles after the start edge (early exit).
- Wrap-around, `y`=2, `c`=0, `d`=3: 18 mod 16 = 2.
  - Response: `found`=1, `s_out`=6, `a_out`=3, `b_out`=3.
  - `done` 8 cycles after the start edge.
- No solution, `y`=3, `c`=0, `d`=2 (products are always even):
  - Response: `found`=0, all result outputs 0.
  - `done` 8 cycles after the start edge.
- Degenerate `d`=0, `y`=14, `c`=2:
  - Response: `found`=1, `s_out`=0, `done` after 2 cycles.
  - With `INV_SOLN_COUNT_EN`: `count`=7, `done` after 8 cycles.
- Handshake:
  - Pulse `start` while `busy`. Required response: ignored, and the result is unchanged.
  - Pulse `start` in the cycle after `done`. Required response: accepted.
- Assert `rst_n`=0 mid-search, at candidate 3 of `y`=2, `c`=0, `d`=3:
  - Required response: all outputs 0 immediately, no `done` pulse.
  - A fresh `start` after release gives the full correct result.
